// File: rtl/shift_register_pkg.sv
// Shared mode encoding and default sizing for the universal shift register.
// The optional fill_done pulse is controlled by the SHREG_FILL_DONE_EN macro.
package shift_register_pkg;

   typedef enum logic [2:0] {
      SHREG_HOLD  = 3'b000,
      SHREG_SHR   = 3'b001,
      SHREG_SHL   = 3'b010,
      SHREG_ROTR  = 3'b011,
      SHREG_ROTL  = 3'b100,
      SHREG_LOAD  = 3'b101,
      SHREG_CLEAR = 3'b110,
      SHREG_RSVD  = 3'b111
   } shreg_mode_e;

   localparam int unsigned SHREG_DATA_W_DEF = 1;
   localparam int unsigned SHREG_DEPTH_DEF  = 8;

endpackage

// File: rtl/shreg_fill_counter.sv
// Saturating fill-level counter with full/empty flags for the shift register.
// SHREG_FILL_DONE_EN adds a registered pulse when a shift makes the register full.
module shreg_fill_counter
   import shift_register_pkg::*;
#(
   parameter  int unsigned DEPTH = SHREG_DEPTH_DEF,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             set_full,
   input  logic             clr,
`ifdef SHREG_FILL_DONE_EN
   output logic             fill_done,
`endif
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (set_full) begin
         count_q <= CNT_W'(DEPTH);
      end else if (inc && (count_q != CNT_W'(DEPTH))) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

`ifdef SHREG_FILL_DONE_EN
   logic fill_done_q;

   // Only a shift crossing DEPTH-1 -> DEPTH pulses; LOAD and shifts while full do not.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fill_done_q <= 1'b0;
      end else begin
         fill_done_q <= inc && !clr && !set_full && (count_q == CNT_W'(DEPTH - 1));
      end
   end

   assign fill_done = fill_done_q;
`endif

   assign count = count_q;
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/shift_register_universal.sv
// Multi-lane universal shift register: hold, shift, rotate, load, clear, with fill tracking.
// Define SHREG_FILL_DONE_EN to expose the fill_done pulse output.
module shift_register_universal
   import shift_register_pkg::*;
#(
   parameter  int unsigned DATA_W = SHREG_DATA_W_DEF,
   parameter  int unsigned DEPTH  = SHREG_DEPTH_DEF,
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic [2:0]              mode,
   input  logic [DATA_W-1:0]       ser_in_l,
   input  logic [DATA_W-1:0]       ser_in_r,
   input  logic [DATA_W*DEPTH-1:0] par_in,
   output logic [DATA_W*DEPTH-1:0] par_out,
   output logic [DATA_W-1:0]       ser_out_r,
   output logic [DATA_W-1:0]       ser_out_l,
   output logic [CNT_W-1:0]        count,
`ifdef SHREG_FILL_DONE_EN
   output logic                    fill_done,
`endif
   output logic                    full,
   output logic                    empty
);

   // Packed so that element i lines up with par_in/par_out slice i.
   logic [DEPTH-1:0][DATA_W-1:0] stage_q;
   logic [DEPTH-1:0][DATA_W-1:0] stage_d;
   shreg_mode_e                  mode_e;
   logic                         cnt_inc;
   logic                         cnt_set_full;
   logic                         cnt_clr;

   assign mode_e = shreg_mode_e'(mode);

   // Unknown or reserved modes fall to the default arm and leave the stages untouched.
   always_comb begin
      stage_d = stage_q;
      if (en) begin
         case (mode_e)
            SHREG_SHR:   stage_d = {ser_in_l, stage_q[DEPTH-1:1]};
            SHREG_SHL:   stage_d = {stage_q[DEPTH-2:0], ser_in_r};
            SHREG_ROTR:  stage_d = {stage_q[0], stage_q[DEPTH-1:1]};
            SHREG_ROTL:  stage_d = {stage_q[DEPTH-2:0], stage_q[DEPTH-1]};
            SHREG_LOAD:  stage_d = par_in;
            SHREG_CLEAR: stage_d = '0;
            default:     stage_d = stage_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign cnt_inc      = en && ((mode_e == SHREG_SHR) || (mode_e == SHREG_SHL));
   assign cnt_set_full = en && (mode_e == SHREG_LOAD);
   assign cnt_clr      = en && (mode_e == SHREG_CLEAR);

   shreg_fill_counter #(
      .DEPTH (DEPTH)
   ) u_fill_counter (
      .clk       (clk),
      .reset     (reset),
      .inc       (cnt_inc),
      .set_full  (cnt_set_full),
      .clr       (cnt_clr),
`ifdef SHREG_FILL_DONE_EN
      .fill_done (fill_done),
`endif
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   assign par_out   = stage_q;
   assign ser_out_r = stage_q[0];
   assign ser_out_l = stage_q[DEPTH-1];

   mode_known_chk: assert property (@(posedge clk) disable iff (!reset) en |-> !$isunknown(mode));

endmodule

// File: tb/tb_shift_register_universal.sv
// Scoreboard bench for shift_register_universal: a 1x4 and an 8x3 instance, directed vectors.
// Checks fill_done as well when SHREG_FILL_DONE_EN is defined.
module tb_shift_register_universal;
   import shift_register_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: DATA_W=1, DEPTH=4
   logic        rst_a, en_a;
   logic [2:0]  mode_a;
   logic [0:0]  sl_in_a, sr_in_a;
   logic [3:0]  par_in_a, par_a;
   logic [0:0]  sor_a, sol_a;
   logic [2:0]  cnt_a;
   logic        full_a, empty_a;

   // Instance B: DATA_W=8, DEPTH=3
   logic        rst_b, en_b;
   logic [2:0]  mode_b;
   logic [7:0]  sl_in_b, sr_in_b;
   logic [23:0] par_in_b, par_b;
   logic [7:0]  sor_b, sol_b;
   logic [1:0]  cnt_b;
   logic        full_b, empty_b;

`ifdef SHREG_FILL_DONE_EN
   logic        fd_a, fd_b;
`endif

   shift_register_universal #(.DATA_W(1), .DEPTH(4)) u_a (
      .clk       (clk),
      .reset     (rst_a),
      .en        (en_a),
      .mode      (mode_a),
      .ser_in_l  (sl_in_a),
      .ser_in_r  (sr_in_a),
      .par_in    (par_in_a),
      .par_out   (par_a),
      .ser_out_r (sor_a),
      .ser_out_l (sol_a),
      .count     (cnt_a),
`ifdef SHREG_FILL_DONE_EN
      .fill_done (fd_a),
`endif
      .full      (full_a),
      .empty     (empty_a)
   );

   shift_register_universal #(.DATA_W(8), .DEPTH(3)) u_b (
      .clk       (clk),
      .reset     (rst_b),
      .en        (en_b),
      .mode      (mode_b),
      .ser_in_l  (sl_in_b),
      .ser_in_r  (sr_in_b),
      .par_in    (par_in_b),
      .par_out   (par_b),
      .ser_out_r (sor_b),
      .ser_out_l (sol_b),
      .count     (cnt_b),
`ifdef SHREG_FILL_DONE_EN
      .fill_done (fd_b),
`endif
      .full      (full_b),
      .empty     (empty_b)
   );

   typedef struct {
      int          dut;
      logic [23:0] par;
      int          cnt;
      logic        fd;
      string       name;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   function automatic void push(int d, logic [23:0] p, int c, logic fd, string nm);
      exp_t e;
      e.dut  = d;
      e.par  = p;
      e.cnt  = c;
      e.fd   = fd;
      e.name = nm;
      q.push_back(e);
   endfunction

   // Monitor: outputs are stable around the falling edge, so all pending expectations are checked there.
   exp_t        m_e;
   logic [23:0] m_par;
   logic [7:0]  m_sr, m_sl, w_sr, w_sl;
   int          m_cnt;
   logic        m_full, m_empty, m_fd, w_full, w_empty, m_ok;

   always @(negedge clk) begin
      while (q.size() != 0) begin
         m_e  = q.pop_front();
         m_fd = 1'b0;
         if (m_e.dut == 0) begin
            m_par   = {20'h0, par_a};
            m_sr    = {7'h0, sor_a};
            m_sl    = {7'h0, sol_a};
            m_cnt   = int'(cnt_a);
            m_full  = full_a;
            m_empty = empty_a;
`ifdef SHREG_FILL_DONE_EN
            m_fd    = fd_a;
`endif
            w_sr    = {7'h0, m_e.par[0]};
            w_sl    = {7'h0, m_e.par[3]};
            w_full  = (m_e.cnt == 4);
         end else begin
            m_par   = par_b;
            m_sr    = sor_b;
            m_sl    = sol_b;
            m_cnt   = int'(cnt_b);
            m_full  = full_b;
            m_empty = empty_b;
`ifdef SHREG_FILL_DONE_EN
            m_fd    = fd_b;
`endif
            w_sr    = m_e.par[7:0];
            w_sl    = m_e.par[23:16];
            w_full  = (m_e.cnt == 3);
         end
         w_empty = (m_e.cnt == 0);
         m_ok = (m_par === m_e.par) && (m_cnt == m_e.cnt) && (m_sr === w_sr) && (m_sl === w_sl)
                && (m_full === w_full) && (m_empty === w_empty);
`ifdef SHREG_FILL_DONE_EN
         m_ok = m_ok && (m_fd === m_e.fd);
`endif
         total++;
         if (!m_ok) begin
            bad++;
            $display("FAIL %s: got par=%h cnt=%0d sr=%h sl=%h full=%b empty=%b fd=%b, want par=%h cnt=%0d sr=%h sl=%h full=%b empty=%b fd=%b",
                     m_e.name, m_par, m_cnt, m_sr, m_sl, m_full, m_empty, m_fd,
                     m_e.par, m_e.cnt, w_sr, w_sl, w_full, w_empty, m_e.fd);
         end
      end
   end

   task automatic step_a(logic e, logic [2:0] m, logic sl, logic sr, logic [3:0] p,
                         logic [3:0] ep, int ec, logic efd, string nm);
      @(negedge clk);
      en_a = e; mode_a = m; sl_in_a = sl; sr_in_a = sr; par_in_a = p;
      @(posedge clk);
      #1 en_a = 1'b0;
      push(0, {20'h0, ep}, ec, efd, nm);
   endtask

   task automatic step_b(logic e, logic [2:0] m, logic [7:0] sl, logic [7:0] sr, logic [23:0] p,
                         logic [23:0] ep, int ec, logic efd, string nm);
      @(negedge clk);
      en_b = e; mode_b = m; sl_in_b = sl; sr_in_b = sr; par_in_b = p;
      @(posedge clk);
      #1 en_b = 1'b0;
      push(1, ep, ec, efd, nm);
   endtask

   task automatic async_rst_b(string nm);
      @(posedge clk);
      #2 rst_b = 1'b0;
      #1 push(1, 24'h0, 0, 1'b0, nm);
      @(posedge clk);
      #1 push(1, 24'h0, 0, 1'b0, {nm, "_held"});
      @(negedge clk);
      rst_b = 1'b1;
   endtask

   initial begin
      rst_a = 1'b0; en_a = 1'b0; mode_a = 3'b000; sl_in_a = '0; sr_in_a = '0; par_in_a = '0;
      rst_b = 1'b0; en_b = 1'b0; mode_b = 3'b000; sl_in_b = '0; sr_in_b = '0; par_in_b = '0;
      #2;
      push(0, 24'h0, 0, 1'b0, "a_reset");
      push(1, 24'h0, 0, 1'b0, "b_reset");
      @(negedge clk);
      rst_a = 1'b1;
      rst_b = 1'b1;

      step_a(1, SHREG_SHR,   1, 0, 4'h0, 4'b1000, 1, 0, "a_shr1");
      step_a(1, SHREG_SHR,   0, 0, 4'h0, 4'b0100, 2, 0, "a_shr2");
      step_a(1, SHREG_SHR,   1, 0, 4'h0, 4'b1010, 3, 0, "a_shr3");
      step_a(1, SHREG_SHR,   1, 0, 4'h0, 4'b1101, 4, 1, "a_shr4_full");
      step_a(1, SHREG_SHR,   0, 0, 4'h0, 4'b0110, 4, 0, "a_shr_sat");
      step_a(1, SHREG_ROTL,  1, 1, 4'h0, 4'b1100, 4, 0, "a_rotl1");
      step_a(1, SHREG_ROTL,  1, 1, 4'h0, 4'b1001, 4, 0, "a_rotl2");
      step_a(1, SHREG_LOAD,  0, 0, 4'b0011, 4'b0011, 4, 0, "a_load");
      step_a(1, SHREG_SHL,   0, 1, 4'h0, 4'b0111, 4, 0, "a_shl");
      step_a(1, SHREG_CLEAR, 1, 1, 4'hF, 4'b0000, 0, 0, "a_clear");
      step_a(0, SHREG_SHL,   1, 1, 4'h0, 4'b0000, 0, 0, "a_en0");
      step_a(1, SHREG_SHL,   0, 1, 4'h0, 4'b0001, 1, 0, "a_shl_from_empty");
      step_a(1, SHREG_ROTR,  0, 0, 4'h0, 4'b1000, 1, 0, "a_rotr");
      step_a(1, SHREG_RSVD,  1, 1, 4'hF, 4'b1000, 1, 0, "a_rsvd");

      step_b(1, SHREG_LOAD,  8'h00, 8'h00, 24'hC35AFF, 24'hC35AFF, 3, 0, "b_load");
      step_b(1, SHREG_ROTR,  8'h99, 8'h99, 24'h0,      24'hFFC35A, 3, 0, "b_rotr1");
      step_b(1, SHREG_ROTR,  8'h99, 8'h99, 24'h0,      24'h5AFFC3, 3, 0, "b_rotr2");
      step_b(1, SHREG_ROTR,  8'h99, 8'h99, 24'h0,      24'hC35AFF, 3, 0, "b_rotr3");
      step_b(0, SHREG_SHR,   8'h77, 8'h00, 24'h0,      24'hC35AFF, 3, 0, "b_en0_shr");
      async_rst_b("b_async_rst_loaded");
      step_b(1, SHREG_SHR,   8'h11, 8'h00, 24'h0,      24'h110000, 1, 0, "b_shr1");
      step_b(1, SHREG_SHR,   8'h22, 8'h00, 24'h0,      24'h221100, 2, 0, "b_shr2");
      step_b(1, SHREG_RSVD,  8'h33, 8'h33, 24'hFFFFFF, 24'h221100, 2, 0, "b_rsvd");
      async_rst_b("b_async_rst_cnt2");
      step_b(1, SHREG_SHR,   8'h33, 8'h00, 24'h0,      24'h330000, 1, 0, "b_shr_after_rst");
      step_b(1, SHREG_SHL,   8'h00, 8'h44, 24'h0,      24'h000044, 2, 0, "b_shl1");
      step_b(1, SHREG_SHL,   8'h00, 8'h55, 24'h0,      24'h004455, 3, 1, "b_shl2_full");
      step_b(1, SHREG_SHR,   8'hEE, 8'h00, 24'h0,      24'hEE0044, 3, 0, "b_shr_when_full");

      for (int i = 0; i < 20; i++) begin
         if (q.size() == 0) break;
         @(negedge clk);
         #1;
      end
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: pending=%0d, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
